// File: rtl/irom_stream_reader.sv
// ---------------------------------------------------------------------------
// irom_stream_reader
//
// Reads a whole image out of a synchronous image ROM (address 0 .. NWORDS-1)
// on each accepted start request and replays it as an ordered pixel stream
// with valid/ready backpressure. ROM data returns one cycle after the read
// request, so each issued read is tracked by a one-deep in-flight flag and
// captured into a small output FIFO on the following edge.
//
// Ports
//   clk        in   rising-edge clock, shared with the ROM
//   reset_n    in   synchronous active-low reset
//   start      in   one-cycle request to fetch and stream one image
//   IROM_EN    out  ROM chip enable, active-low (read when 0 at clk rise)
//   IROM_A     out  ROM address [ADDR_W]
//   IROM_Q     in   ROM read data [DATA_W], valid the edge after the request
//   out_data   out  pixel at FIFO head [DATA_W], 0 when the FIFO is empty
//   out_valid  out  FIFO non-empty
//   out_ready  in   downstream accept
//   out_last   out  head pixel came from address NWORDS-1
//   busy       out  image transfer in progress
//   done       out  one-cycle pulse after the last pixel is accepted
//
// Parameter constraints: NWORDS <= 2**ADDR_W, FIFO_DEPTH >= 2.
//
// Output handshake: a pixel moves on every rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and once
// out_valid is 1 the head entry (out_data/out_last) holds until it moves.
// ---------------------------------------------------------------------------
module irom_stream_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int NWORDS     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              IROM_EN,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Request side
  logic [ADDR_W-1:0] req_cnt;
  logic              inflight;
  logic              inflight_last;
  logic              issue;

  // Output FIFO
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;

  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;
  logic              done_set;
  logic              done_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // A push happens exactly on the edge after an issued read; IROM_Q is not
  // looked at on any other edge, so a stale ROM output cannot leak in.
  assign push = inflight;
  assign pop  = out_valid & out_ready;

  // Slots already committed this cycle: stored words plus the word on its
  // way back from the ROM, minus the one leaving now. Counting the pop here
  // is what lets a depth-2 buffer sustain one pixel per cycle.
  assign occupancy = {1'b0, fifo_count}
                   + {{CNT_W{1'b0}}, inflight}
                   - {{CNT_W{1'b0}}, pop};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and read issue
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        // done_q high means we are in the completion cycle; a start there
        // is dropped rather than queued.
        if (start && !done_q) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (occupancy < {1'b0, DEPTH_C}) begin
          issue = 1'b1;
          if (req_cnt == LAST_ADDR) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finished once nothing is returning from the ROM and the last
        // stored pixel is leaving on this edge (or the FIFO is empty).
        if (!inflight && (occupancy == '0)) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request counter and in-flight tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (req_cnt == LAST_ADDR);
      done_q        <= done_set;
      if (done_set) begin
        // Park at 0 so the next image starts from the first word.
        req_cnt <= '0;
      end else if (issue && (req_cnt != LAST_ADDR)) begin
        req_cnt <= req_cnt + ADDR_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO bookkeeping (reset flushes it by clearing the pointers)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= IROM_Q;
      last_mem[wr_ptr] <= inflight_last;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign IROM_EN   = ~issue;
  assign IROM_A    = req_cnt;
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_last  = out_valid & last_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule
